// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Port numbering matches the packing of the per-port request buses.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_SPI = 1'b0;
    localparam logic PORT_I2C = 1'b1;

    // One-hot per-port mask for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational two-way grant: single requester wins, otherwise fixed
// priority to SPI or round-robin away from the last granted port.
module rr_arbiter (
    input  logic [1:0] req,
    input  logic       prio_mode,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_port
);
    import reg_arb_pkg::*;

    // Winner selection from the current request pattern.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_SPI;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant_port  = PORT_SPI;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_port  = PORT_I2C;
            end
            2'b11: begin
                grant_valid = 1'b1;
                if (prio_mode) begin
                    grant_port = PORT_SPI;
                end else if (last_grant == PORT_SPI) begin
                    grant_port = PORT_I2C;
                end else begin
                    grant_port = PORT_SPI;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_port  = PORT_SPI;
            end
        endcase
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates SPI/I2C single-register accesses onto the shared register bank,
// sequences the bank handshake with a timeout and returns ack/err/rdata.
module reg_bank_arbiter #(
    parameter int REG_W   = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  prio_mode,
    input  logic [1:0]            req,
    input  logic [1:0]            wr_rdn,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*REG_W-1:0]    wdata,
    output logic [1:0]            ack,
    output logic [1:0]            err,
    output logic [REG_W-1:0]      rdata,
    output logic                  busy,
    output logic                  owner,
    output logic                  bank_req,
    output logic                  bank_wr_rdn,
    output logic [ADDR_W-1:0]     bank_addr,
    output logic [REG_W-1:0]      bank_wdata,
    input  logic                  bank_ack,
    input  logic                  bank_err,
    input  logic [REG_W-1:0]      bank_rdata
);
    import reg_arb_pkg::*;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              timeout_s;
    logic              grant_valid_s;
    logic              grant_port_s;
    logic              grant_load_s;
    logic              last_grant_r;
    logic              owner_r;
    logic [1:0]        ack_r;
    logic [1:0]        ack_s;
    logic [1:0]        err_r;
    logic [1:0]        err_s;
    logic [REG_W-1:0]  rdata_r;
    logic [REG_W-1:0]  rdata_s;
    logic              rdata_load_s;
    logic              busy_r;
    logic              bank_req_r;
    logic              bank_wr_rdn_r;
    logic [ADDR_W-1:0] bank_addr_r;
    logic [REG_W-1:0]  bank_wdata_r;

    rr_arbiter u_rr_arbiter (
        .req         (req),
        .prio_mode   (prio_mode),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_port  (grant_port_s)
    );

    // The WAIT cycle that brings the count to TIMEOUT is the last one.
    assign timeout_s = ((cnt_r + CNT_W'(1)) == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ena && grant_valid_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = WAIT;
            WAIT: begin
                if (bank_ack || timeout_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values for the registered outputs and the timeout counter.
    always_comb begin
        grant_load_s = 1'b0;
        ack_s        = 2'b00;
        err_s        = 2'b00;
        rdata_load_s = 1'b0;
        rdata_s      = rdata_r;
        cnt_s        = cnt_r;
        case (state_r)
            IDLE: begin
                if (ena && grant_valid_s) begin
                    grant_load_s = 1'b1;
                end else begin
                    grant_load_s = 1'b0;
                end
            end
            ISSUE: cnt_s = '0;
            WAIT: begin
                if (bank_ack) begin
                    ack_s        = port_onehot(owner_r);
                    err_s        = bank_err ? port_onehot(owner_r) : 2'b00;
                    rdata_load_s = 1'b1;
                    rdata_s      = bank_rdata;
                end else if (timeout_s) begin
                    ack_s        = port_onehot(owner_r);
                    err_s        = port_onehot(owner_r);
                    rdata_load_s = 1'b1;
                    rdata_s      = '0;
                end else begin
                    cnt_s = (cnt_r == CNT_LAST) ? cnt_r : cnt_r + CNT_W'(1);
                end
            end
            RESP: cnt_s = cnt_r;
            default: begin
                grant_load_s = 1'b0;
                cnt_s        = '0;
            end
        endcase
    end

    // Output and datapath registers; grant data is latched only at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= '0;
            last_grant_r  <= PORT_I2C;
            owner_r       <= PORT_SPI;
            ack_r         <= 2'b00;
            err_r         <= 2'b00;
            rdata_r       <= '0;
            busy_r        <= 1'b0;
            bank_req_r    <= 1'b0;
            bank_wr_rdn_r <= 1'b0;
            bank_addr_r   <= '0;
            bank_wdata_r  <= '0;
        end else begin
            cnt_r      <= cnt_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
            busy_r     <= (next_state_s != IDLE);
            bank_req_r <= grant_load_s;
            if (rdata_load_s) begin
                rdata_r <= rdata_s;
            end
            if (grant_load_s) begin
                owner_r       <= grant_port_s;
                last_grant_r  <= grant_port_s;
                bank_wr_rdn_r <= grant_port_s ? wr_rdn[1] : wr_rdn[0];
                bank_addr_r   <= grant_port_s ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                bank_wdata_r  <= grant_port_s ? wdata[2*REG_W-1:REG_W] : wdata[REG_W-1:0];
            end
        end
    end

    assign ack         = ack_r;
    assign err         = err_r;
    assign rdata       = rdata_r;
    assign busy        = busy_r;
    assign owner       = owner_r;
    assign bank_req    = bank_req_r;
    assign bank_wr_rdn = bank_wr_rdn_r;
    assign bank_addr   = bank_addr_r;
    assign bank_wdata  = bank_wdata_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (default parameters).
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        prio_mode;
    logic [1:0]  req;
    logic [1:0]  wr_rdn;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic        owner;
    logic        bank_req;
    logic        bank_wr_rdn;
    logic [3:0]  bank_addr;
    logic [7:0]  bank_wdata;
    logic        bank_ack;
    logic        bank_err;
    logic [7:0]  bank_rdata;

    int errors = 0;
    int checks = 0;

    reg_bank_arbiter #(.REG_W(8), .ADDR_W(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .prio_mode   (prio_mode),
        .req         (req),
        .wr_rdn      (wr_rdn),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .busy        (busy),
        .owner       (owner),
        .bank_req    (bank_req),
        .bank_wr_rdn (bank_wr_rdn),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_ack    (bank_ack),
        .bank_err    (bank_err),
        .bank_rdata  (bank_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bank_req(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (bank_req === 1'b1) seen = 1'b1;
        end
    endtask

    // Called right after bank_req is seen; returns in the cycle ack is expected.
    task automatic bank_reply(input logic [7:0] d, input logic e);
        tick();
        bank_ack   = 1'b1;
        bank_rdata = d;
        bank_err   = e;
        tick();
        bank_ack   = 1'b0;
        bank_err   = 1'b0;
        bank_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({ack, err, rdata, busy, owner, bank_req, bank_wr_rdn, bank_addr, bank_wdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h busy=%b owner=%b bank_req=%b bank_addr=%h, required all 0",
                     ack, err, rdata, busy, owner, bank_req, bank_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        addr   = {4'd0, 4'd3};
        wr_rdn = 2'b00;
        req    = 2'b01;
        tick();
        checks++;
        if ({bank_req, bank_wr_rdn, bank_addr} !== {1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL single_issue: got bank_req=%b wr=%b addr=%h, required 1 0 3", bank_req, bank_wr_rdn, bank_addr);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        bank_reply(8'hA5, 1'b0);
        checks++;
        if ({ack, err, rdata, owner} !== {2'b01, 2'b00, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL single_ack: got ack=%b err=%b rdata=%h owner=%b, required 01 00 a5 0", ack, err, rdata, owner);
        end
        req = 2'b00;
        tick();
        checks++;
        if ({ack, busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: got ack=%b busy=%b, required 00 0", ack, busy);
        end
    endtask

    task automatic test_round_robin();
        bit   seen;
        logic exp_port;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        prio_mode = 1'b0;
        addr      = {4'd9, 4'd5};
        req       = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_port = (g % 2 == 1);
            wait_bank_req(8, seen);
            checks++;
            if (!seen || owner !== exp_port || bank_addr !== (exp_port ? 4'd9 : 4'd5)) begin
                errors++;
                $display("FAIL rr_grant%0d: got seen=%b owner=%b bank_addr=%h, required owner=%b", g, seen, owner, bank_addr, exp_port);
            end
            bank_reply(8'h10 + 8'(g), 1'b0);
            checks++;
            if (ack !== (exp_port ? 2'b10 : 2'b01) || rdata !== 8'h10 + 8'(g)) begin
                errors++;
                $display("FAIL rr_ack%0d: got ack=%b rdata=%h, required port %b", g, ack, rdata, exp_port);
            end
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_fixed_priority();
        bit seen;
        prio_mode = 1'b1;
        req       = 2'b11;
        for (int g = 0; g < 3; g++) begin
            wait_bank_req(8, seen);
            checks++;
            if (!seen || owner !== 1'b0 || bank_addr !== 4'd5) begin
                errors++;
                $display("FAIL prio_grant%0d: got seen=%b owner=%b bank_addr=%h, required owner 0", g, seen, owner, bank_addr);
            end
            bank_reply(8'h20, 1'b0);
            checks++;
            if (ack !== 2'b01) begin
                errors++;
                $display("FAIL prio_ack%0d: got %b, required 01", g, ack);
            end
        end
        req       = 2'b00;
        prio_mode = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_bank_error();
        bit seen;
        req    = 2'b10;
        wr_rdn = 2'b10;
        addr   = {4'd7, 4'd0};
        wdata  = {8'h3C, 8'h00};
        wait_bank_req(4, seen);
        checks++;
        if (!seen || {owner, bank_wr_rdn, bank_addr, bank_wdata} !== {1'b1, 1'b1, 4'd7, 8'h3C}) begin
            errors++;
            $display("FAIL err_issue: got seen=%b owner=%b wr=%b addr=%h wdata=%h, required 1 1 7 3c",
                     seen, owner, bank_wr_rdn, bank_addr, bank_wdata);
        end
        bank_reply(8'h11, 1'b1);
        checks++;
        if ({ack, err, rdata} !== {2'b10, 2'b10, 8'h11}) begin
            errors++;
            $display("FAIL err_ack: got ack=%b err=%b rdata=%h, required 10 10 11", ack, err, rdata);
        end
        req    = 2'b00;
        wr_rdn = 2'b00;
        tick();
        checks++;
        if ({ack, err} !== 4'b0000) begin
            errors++;
            $display("FAIL err_clear: got ack=%b err=%b, required 00 00", ack, err);
        end
    endtask

    task automatic test_timeout();
        int n;
        addr = {4'd0, 4'd2};
        req  = 2'b01;
        tick();
        checks++;
        if (bank_req !== 1'b1) begin
            errors++;
            $display("FAIL to_issue: got bank_req=%b, required 1", bank_req);
        end
        n = 1;
        while (ack === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL to_latency: got ack at cycle %0d, required 17", n);
        end
        checks++;
        if ({ack, err, rdata} !== {2'b01, 2'b01, 8'h00}) begin
            errors++;
            $display("FAIL to_resp: got ack=%b err=%b rdata=%h, required 01 01 00", ack, err, rdata);
        end
        req = 2'b00;
        tick();
        bank_ack   = 1'b1;
        bank_rdata = 8'hEE;
        tick();
        bank_ack   = 1'b0;
        bank_rdata = 8'h00;
        checks++;
        if ({ack, busy, bank_req} !== 4'b0000) begin
            errors++;
            $display("FAIL late_ack: got ack=%b busy=%b bank_req=%b, required 00 0 0", ack, busy, bank_req);
        end
        tick();
        checks++;
        if ({ack, rdata} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL late_ack_hold: got ack=%b rdata=%h, required 00 00", ack, rdata);
        end
    endtask

    task automatic test_rst_mid();
        bit seen;
        addr = {4'd9, 4'd5};
        req  = 2'b01;
        wait_bank_req(4, seen);
        tick();
        rst = 1'b1;
        req = 2'b00;
        tick();
        checks++;
        if (!seen || {ack, err, rdata, busy, owner, bank_req, bank_wr_rdn, bank_addr, bank_wdata} !== 34'd0) begin
            errors++;
            $display("FAIL rst_mid: got seen=%b ack=%b busy=%b bank_addr=%h owner=%b, required all 0",
                     seen, ack, busy, bank_addr, owner);
        end
        rst       = 1'b0;
        prio_mode = 1'b0;
        req       = 2'b11;
        wait_bank_req(4, seen);
        checks++;
        if (!seen || owner !== 1'b0) begin
            errors++;
            $display("FAIL rst_last_grant: got seen=%b owner=%b, required owner 0", seen, owner);
        end
        bank_reply(8'h42, 1'b0);
        req = 2'b00;
        checks++;
        if (ack !== 2'b01) begin
            errors++;
            $display("FAIL rst_after_ack: got %b, required 01", ack);
        end
        tick();
        tick();
    endtask

    task automatic test_ena();
        bit seen;
        int hits;
        ena  = 1'b0;
        req  = 2'b11;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bank_req !== 1'b0 || busy !== 1'b0) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL ena_block: got %0d active cycles, required 0", hits);
        end
        ena = 1'b1;
        req = 2'b01;
        wait_bank_req(4, seen);
        ena = 1'b0;
        bank_reply(8'h77, 1'b0);
        checks++;
        if (!seen || ack !== 2'b01 || rdata !== 8'h77) begin
            errors++;
            $display("FAIL ena_drop: got seen=%b ack=%b rdata=%h, required 01 77", seen, ack, rdata);
        end
        req  = 2'b10;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bank_req !== 1'b0) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL ena_no_regrant: got %0d bank_req cycles, required 0", hits);
        end
        ena = 1'b1;
        wait_bank_req(4, seen);
        checks++;
        if (!seen || owner !== 1'b1) begin
            errors++;
            $display("FAIL ena_resume: got seen=%b owner=%b, required 1 1", seen, owner);
        end
        bank_reply(8'h00, 1'b0);
        req = 2'b00;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        ena        = 1'b1;
        prio_mode  = 1'b0;
        req        = 2'b00;
        wr_rdn     = 2'b00;
        addr       = 8'h00;
        wdata      = 16'h0000;
        bank_ack   = 1'b0;
        bank_err   = 1'b0;
        bank_rdata = 8'h00;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_bank_error();
        test_timeout();
        test_rst_mid();
        test_ena();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-requester arbiter and access sequencer for the shared configuration/status register bank. The SPI peripheral (port 0) and the I2C peripheral (port 1) each issue single-register read/write requests. The block grants one at a time using round-robin or fixed priority, sequences the bank access and routes the ack, read data and error back to the winner. A bank that fails to respond is caught by a timeout. This block replaces the static peripheral select in the peripheral wrapper.

## Interface
Parameters:
- REG_W, 8, register/data width
- ADDR_W, 4, bank address width
- TIMEOUT, 15, max cycles waiting for bank_ack before error (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ena  in  1  when low, no new grants; an in-flight access completes
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (port 0 always wins)
- req  in  2  per-port request level; req[i] held until ack[i]
- wr_rdn  in  2  per-port 1 = write, 0 = read
- addr  in  2*ADDR_W  per-port address; port i in [i*ADDR_W +: ADDR_W]
- wdata  in  2*REG_W  per-port write data, same packing
- ack  out  2  one-cycle completion pulse to the granted port
- err  out  2  valid with ack; 1 = bank error or timeout
- rdata  out  REG_W  read data, valid with ack; shared by both ports
- busy  out  1  high in any state other than IDLE
- owner  out  1  index of the granted port; holds its value after completion
- bank_req  out  1  one-cycle access strobe to the bank
- bank_wr_rdn  out  1  access direction
- bank_addr  out  ADDR_W  access address
- bank_wdata  out  REG_W  write data
- bank_ack  in  1  bank completion; arrives at the earliest 1 cycle after bank_req
- bank_err  in  1  bank error, valid with bank_ack
- bank_rdata  in  REG_W  bank read data, valid with bank_ack

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If ena=1 and any req is high, pick the winner, then latch its wr_rdn, addr and wdata into the bank_* registers.
  - Set owner to the winner, set last_grant to the winner, and go to ISSUE.
- ISSUE: bank_req=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On bank_ack=1, capture bank_rdata and bank_err, then go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set err=1 and rdata=0, then go to RESP.
- RESP: ack[owner]=1 and err[owner] valid for one cycle; go to IDLE.
- Arbitration:
  - With one request, that port wins.
  - With both requests and prio_mode=1, port 0 wins.
  - With both requests and prio_mode=0, the port != last_grant wins.
  - last_grant resets to 1, so port 0 wins the first contention.
- Requester rule: req[i] must be low in the cycle after ack[i]. The requester clears its req flop on the edge that samples ack=1. The arbiter then cannot re-grant the same transaction.
- Hold rules:
  - bank_wr_rdn, bank_addr and bank_wdata hold their values from ISSUE until the next grant.
  - rdata holds its value until the next RESP.
- A bank_ack seen in IDLE or ISSUE, or after a timeout, is ignored.
- A write returns rdata=0 unless the bank supplies data.
- Requester inputs are ignored outside IDLE; a port change during an access has no effect.
- ena falling during ISSUE, WAIT or RESP: the access completes normally, and no grant occurs while ena=0.
- Timeout counter width is $clog2(TIMEOUT+1) and the counter saturates; no wrap-around.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: ack, err, rdata, busy, owner, bank_req, bank_wr_rdn, bank_addr, bank_wdata.
  - last_grant=1, counter 0.
- rst mid-access forces IDLE on the next edge and drops any pending ack. The bank may receive an orphan bank_req, which is not retried.
- Latency, with req sampled high in IDLE at cycle 0:
  - bank_req at cycle 1.
  - If bank_ack arrives at cycle 1+k (k≥1), ack arrives at cycle 2+k.
  - Minimum request-to-ack latency is 3 cycles.
- Timeout: bank_req at cycle 1, no bank_ack → ack with err=1 at cycle 2+TIMEOUT.
- Back-to-back: the next grant is possible in the IDLE cycle right after RESP. This gives a 4-cycle minimum access period with k=1.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package reg_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - constants PORT_SPI=0 and PORT_I2C=1.
- One sub-module, rr_arbiter: a combinational 2-way grant from req, prio_mode and last_grant.
- The FSM, the timeout counter and the registers live in reg_bank_arbiter.

## Test plan
- Single SPI read: req=01, addr0=3; bank_ack with rdata=0xA5 1 cycle after bank_req → ack=01, rdata=0xA5, err=00, 3 cycles after req.
- Contention, round-robin: req=11 held, prio_mode=0 → grants in order 0,1,0,1; each ack on the correct bit and bank_addr matching the granted port.
- Fixed priority: prio_mode=1, port 0 re-requests continuously → port 1 is never granted while req[0]=1.
- Timeout: TIMEOUT=15, bank never acks → ack[owner]=1, err=1, rdata=0 at cycle 17; a late bank_ack in IDLE is ignored with no ack.
- Bank error: I2C write, bank_ack with bank_err=1 → ack=10, err=10.
- Control: rst during WAIT → all outputs 0 next cycle and last_grant=1. ena=0 with req=11 → no bank_req. ena dropped mid-access → the current ack still arrives.
